// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sequential multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/mult_sign_fix.sv
// rtl/mult_sign_fix.sv - conditional two's-complement negate
// Serves as abs() on operands (neg = sign bit) and as the final product sign fix.
module mult_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle shift-add multiplier producing full hi/lo product
// Fixed latency of DATA_WIDTH iterations; signed mode works on magnitudes and fixes sign at the end.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                  state;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [DATA_WIDTH-1:0]   acc;
  logic                    neg;

  logic                    neg_a;
  logic                    neg_b;
  logic [DATA_WIDTH-1:0]   abs_a;
  logic [DATA_WIDTH-1:0]   abs_b;
  logic [DATA_WIDTH:0]     sum;
  logic [2*DATA_WIDTH-1:0] prod_next;
  logic [2*DATA_WIDTH-1:0] prod_fixed;

  assign neg_a = (is_signed == MODE_SIGNED) & a[DATA_WIDTH-1];
  assign neg_b = (is_signed == MODE_SIGNED) & b[DATA_WIDTH-1];

  mult_sign_fix #(.W(DATA_WIDTH)) u_abs_a (.val(a), .neg(neg_a), .res(abs_a));
  mult_sign_fix #(.W(DATA_WIDTH)) u_abs_b (.val(b), .neg(neg_b), .res(abs_b));

  // The multiplier register doubles as the low half of the product as it shifts out.
  assign sum       = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
  assign prod_next = {sum, mplier[DATA_WIDTH-1:1]};

  mult_sign_fix #(.W(2 * DATA_WIDTH)) u_fix_prod (.val(prod_next), .neg(neg), .res(prod_fixed));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= abs_a;
            mplier <= abs_b;
            neg    <= neg_a ^ neg_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          acc    <= sum[DATA_WIDTH:1];
          mplier <= {sum[0], mplier[DATA_WIDTH-1:1]};
          cnt    <= cnt + CNT_WIDTH'(1);
          if (cnt == LAST_ITER) begin
            {hi, lo} <= prod_fixed;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state != BUSY);
  assign busy  = (state == BUSY);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier at W=32, 16 and 8
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic flush;

  logic        start32, sg32, ready32, busy32, done32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start16, sg16, ready16, busy16, done16;
  logic [15:0] a16, b16, hi16, lo16;
  logic        start8, sg8, ready8, busy8, done8;
  logic [7:0]  a8, b8, hi8, lo8;

  int total = 0;
  int bad   = 0;

  seq_multiplier #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(sg32), .flush(flush),
    .a(a32), .b(b32), .ready(ready32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  seq_multiplier #(.DATA_WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sg16), .flush(flush),
    .a(a16), .b(b16), .ready(ready16), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
  );

  seq_multiplier #(.DATA_WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sg8), .flush(flush),
    .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    case (w)
      8:       return done8;
      16:      return done16;
      default: return done32;
    endcase
  endfunction

  function automatic logic [63:0] prod_of(input int w);
    case (w)
      8:       return {48'd0, hi8, lo8};
      16:      return {32'd0, hi16, lo16};
      default: return {hi32, lo32};
    endcase
  endfunction

  task automatic drive(input int w, input logic st, input logic [31:0] av,
                       input logic [31:0] bv, input logic sg);
    case (w)
      8:       begin start8  = st; a8  = av[7:0];  b8  = bv[7:0];  sg8  = sg; end
      16:      begin start16 = st; a16 = av[15:0]; b16 = bv[15:0]; sg16 = sg; end
      default: begin start32 = st; a32 = av;       b32 = bv;       sg32 = sg; end
    endcase
  endtask

  task automatic run(input int w, input logic [31:0] av, input logic [31:0] bv,
                     input logic sg, input logic [63:0] exp, input string tag);
    int n;
    @(negedge clk);
    drive(w, 1'b1, av, bv, sg);
    @(posedge clk); #1;
    drive(w, 1'b0, av, bv, sg);
    n = 0;
    while (!done_of(w) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(w));
    chk({tag, " product"}, prod_of(w), exp);
    @(posedge clk); #1;
    chk1({tag, " done pulse width"}, done_of(w), 1'b0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    flush = 1'b0;
    drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(16, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(8,  1'b0, 32'd0, 32'd0, 1'b0);

    #12;
    chk("reset product", prod_of(32), 64'd0);
    chk1("reset ready", ready32, 1'b1);
    chk1("reset busy", busy32, 1'b0);
    chk1("reset done", done32, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run(32, 32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, "u32 7x6");
    run(32, 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s32 -3x5");
    run(32, 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, "u32 fffffffdx5");
    run(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u32 max");
    run(32, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s32 min");

    // start during BUSY must be ignored, hi/lo must hold the previous result
    @(negedge clk);
    drive(32, 1'b1, 32'd11, 32'd13, 1'b0);
    @(posedge clk); #1;
    drive(32, 1'b0, 32'd11, 32'd13, 1'b0);
    n = 0;
    while (!done32 && n < 200) begin
      chk1("hs ready low", ready32, 1'b0);
      chk1("hs busy high", busy32, 1'b1);
      chk("hs hold", prod_of(32), 64'h4000_0000_0000_0000);
      if (n == 5) drive(32, 1'b1, 32'd100, 32'd100, 1'b0);
      if (n == 6) drive(32, 1'b0, 32'd100, 32'd100, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    chk("hs latency", 64'(n), 64'd32);
    chk("hs product", prod_of(32), 64'd143);

    // back-to-back start from DONE
    drive(32, 1'b1, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1;
    drive(32, 1'b0, 32'd3, 32'd4, 1'b0);
    chk1("b2b busy", busy32, 1'b1);
    n = 1;
    while (!done32 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b done gap", 64'(n), 64'd33);
    chk("b2b product", prod_of(32), 64'd12);

    // flush after 10 iterations
    @(negedge clk);
    drive(32, 1'b1, 32'd2, 32'd5, 1'b0);
    @(posedge clk); #1;
    drive(32, 1'b0, 32'd2, 32'd5, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk1("flush ready", ready32, 1'b1);
    chk1("flush busy", busy32, 1'b0);
    chk1("flush done", done32, 1'b0);
    chk("flush hold", prod_of(32), 64'd12);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) n++;
    end
    chk("flush no done", 64'(n), 64'd0);

    // asynchronous reset mid-operation
    @(negedge clk);
    drive(32, 1'b1, 32'd9, 32'd9, 1'b0);
    @(posedge clk); #1;
    drive(32, 1'b0, 32'd9, 32'd9, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst product", prod_of(32), 64'd0);
    chk1("arst ready", ready32, 1'b1);
    chk1("arst busy", busy32, 1'b0);
    chk1("arst done", done32, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(32, 32'd2, 32'd3, 1'b0, 64'd6, "u32 2x3 after reset");

    run(8, 32'h07, 32'h06, 1'b0, 64'h002A, "u8 7x6");
    run(8, 32'hFD, 32'h05, 1'b1, 64'hFFF1, "s8 -3x5");
    run(8, 32'hFD, 32'h05, 1'b0, 64'h04F1, "u8 fdx5");
    run(8, 32'hFF, 32'hFF, 1'b0, 64'hFE01, "u8 max");
    run(8, 32'h80, 32'h80, 1'b1, 64'h4000, "s8 min");

    run(16, 32'h1234, 32'h0010, 1'b0, 64'h0001_2340, "u16 1234x10");
    run(16, 32'hFFFD, 32'h0005, 1'b1, 64'hFFFF_FFF1, "s16 -3x5");
    run(16, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE_0001, "u16 max");
    run(16, 32'h8000, 32'h8000, 1'b1, 64'h4000_0000, "s16 min");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
